instr_mem_responder: RTL

Instruction-memory responder: the memory-side end of the fetch interface. Accepts one word-aligned fetch request at a time from the fetch stage and returns the 32-bit instruction after a fixed latency, using a valid/ready handshake on both request and response. A separate program-load write port lets the bench or host preload the program. Sits between instruction_fetch and the program image.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_array.sv | 26 ++
 rtl/instr_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Used by instr_mem_responder and imem_array.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Number of index bits needed to address 'value' words.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one
// asynchronous read port, so a same-edge write is seen only on later reads.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_idx,
  input  logic [31:0]               wr_data,
  input  logic [clog2(DEPTH)-1:0]   rd_idx,
  output logic [31:0]               rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side end of the fetch interface: fixed-latency valid/ready responder
// with a program-load port. Define IMEM_ERR_CHECK_EN for misalign/range errors.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 32,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic              busy
);

  localparam int         IDX_W    = clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] prog_idx;
  logic             req_bad;
  logic             prog_wr;
  logic [31:0]      rd_data;

  assign req_idx  = req_addr[IDX_W+1:2];
  assign prog_idx = prog_addr[IDX_W+1:2];

`ifdef IMEM_ERR_CHECK_EN
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * 4);

  assign req_bad = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= LIMIT);
  assign prog_wr = prog_we && (prog_addr[1:0] == 2'b00) && ({1'b0, prog_addr} >= LIMIT) == 1'b0;
`else
  // Without checking, the byte offset and upper address bits simply wrap away.
  logic unused_addr_bits;

  assign req_bad          = 1'b0;
  assign prog_wr          = prog_we;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0],
                              prog_addr[ADDR_W-1:IDX_W+2], prog_addr[1:0]};
`endif

  imem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .wr_en  (prog_wr),
    .wr_idx (prog_idx),
    .wr_data(prog_data),
    .rd_idx (idx_q),
    .rd_data(rd_data)
  );

  // The array is read on the WAIT->RESP edge; a write on that same edge lands
  // after the sample, giving read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_instr <= 32'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q     <= req_idx;
            err_q     <= req_bad;
            cnt       <= LAT_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_instr <= err_q ? NOP_WORD : rd_data;
            rsp_err   <= err_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
